// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter from reservation-station entries to a single ALU port.
// Tracks in-flight operations, frees completed entries, and drains outstanding work on flush.
module alu_issue_arbiter #(
    parameter int SIZE         = 8,
    parameter int MAX_INFLIGHT = 2,
    localparam int IDXW        = $clog2(SIZE),
    localparam int CNTW        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [SIZE-1:0] rs_ready,
    output logic            alu_valid,
    output logic [IDXW-1:0] alu_idx,
    input  logic            alu_ack,
    input  logic            alu_done,
    input  logic [IDXW-1:0] alu_done_idx,
    output logic [SIZE-1:0] issued,
    output logic [SIZE-1:0] rs_clear,
    output logic [CNTW-1:0] inflight_cnt,
    output logic            busy,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [SIZE-1:0] clear_q, clear_d;
    logic [SIZE-1:0] mask_q, mask_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic            err_q, err_d;

    logic            hs;
    logic            done_ok;
    logic            done_bad;
    logic [SIZE-1:0] cand;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            can_issue;
    logic [IDXW-1:0] rr_next;

    function automatic logic [SIZE-1:0] onehot(input logic [IDXW-1:0] i);
        return SIZE'(1) << i;
    endfunction

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [IDXW:0] rr_pick(input logic [SIZE-1:0] c,
                                              input logic [IDXW-1:0] ptr);
        logic            found;
        logic [IDXW-1:0] sel;
        logic [IDXW-1:0] j;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < SIZE; i++) begin
            j = IDXW'((int'(ptr) + i) % SIZE);
            if (!found && c[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        hs       = (state_q == REQ) && valid_q && alu_ack && !flush;
        done_ok  = alu_done && mask_q[alu_done_idx];
        done_bad = alu_done && !mask_q[alu_done_idx];

        mask_d = mask_q;
        if (hs)
            mask_d = mask_d | onehot(idx_q);
        if (done_ok)
            mask_d = mask_d & ~onehot(alu_done_idx);

        cnt_d = cnt_q;
        if (hs && !done_ok)
            cnt_d = cnt_q + CNTW'(1);
        else if (!hs && done_ok)
            cnt_d = cnt_q - CNTW'(1);

        // An entry freed last cycle stays ineligible until the RS has seen its rs_clear pulse.
        cand                   = rs_ready & ~mask_q & ~clear_q;
        {pick_found, pick_idx} = rr_pick(cand, rr_q);
        can_issue              = pick_found && (cnt_q < CNTW'(MAX_INFLIGHT));
        rr_next                = (idx_q == IDXW'(SIZE - 1)) ? '0 : idx_q + IDXW'(1);

        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        clear_d = '0;
        err_d   = err_q | done_bad;

        if (flush) begin
            valid_d = 1'b0;
            rr_d    = '0;
            state_d = (cnt_d != '0) ? DRAIN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (done_ok)
                        clear_d = onehot(alu_done_idx);
                    if (can_issue) begin
                        state_d = REQ;
                        valid_d = 1'b1;
                        idx_d   = pick_idx;
                    end
                end
                REQ: begin
                    if (done_ok)
                        clear_d = onehot(alu_done_idx);
                    if (hs) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        rr_d    = rr_next;
                    end
                end
                DRAIN: begin
                    if (cnt_d == '0)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            clear_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            clear_q <= clear_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign issued       = hs ? onehot(idx_q) : '0;
    assign alu_valid    = valid_q;
    assign alu_idx      = idx_q;
    assign rs_clear     = clear_q;
    assign inflight_cnt = cnt_q;
    assign busy         = (state_q != IDLE) || (cnt_q != '0);
    assign err          = err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: dispatch order, in-flight limit, hold, wrap, flush/drain, reset.
module tb_alu_issue_arbiter;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] rs_ready;
    logic       alu_valid;
    logic [2:0] alu_idx;
    logic       alu_ack;
    logic       alu_done;
    logic [2:0] alu_done_idx;
    logic [7:0] issued;
    logic [7:0] rs_clear;
    logic [1:0] inflight_cnt;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;

    alu_issue_arbiter #(.SIZE(8), .MAX_INFLIGHT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .rs_ready     (rs_ready),
        .alu_valid    (alu_valid),
        .alu_idx      (alu_idx),
        .alu_ack      (alu_ack),
        .alu_done     (alu_done),
        .alu_done_idx (alu_done_idx),
        .issued       (issued),
        .rs_clear     (rs_clear),
        .inflight_cnt (inflight_cnt),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst)
            n_hs <= 0;
        else if (issued != 8'h00)
            n_hs <= n_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        flush        = 1'b0;
        rs_ready     = 8'h00;
        alu_ack      = 1'b0;
        alu_done     = 1'b0;
        alu_done_idx = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        rs_ready     = 8'hFF;
        alu_ack      = 1'b1;
        alu_done     = 1'b0;
        alu_done_idx = 3'd0;
        #1 rst = 1'b0;
        #2;
        check_eq("rst_valid",    32'(alu_valid),    0);
        check_eq("rst_idx",      32'(alu_idx),      0);
        check_eq("rst_clear",    32'(rs_clear),     0);
        check_eq("rst_cnt",      32'(inflight_cnt), 0);
        check_eq("rst_busy",     32'(busy),         0);
        check_eq("rst_err",      32'(err),          0);
        check_eq("rst_issued",   32'(issued),       0);

        // Two ready entries dispatched in order, then completed
        @(negedge clk);
        rst      = 1'b1;
        rs_ready = 8'b0000_0110;
        alu_ack  = 1'b1;
        step();
        check_eq("a_valid1",  32'(alu_valid), 1);
        check_eq("a_idx1",    32'(alu_idx),   1);
        check_eq("a_issued1", 32'(issued),    32'h02);
        step();
        check_eq("a_valid_gap", 32'(alu_valid),    0);
        check_eq("a_cnt1",      32'(inflight_cnt), 1);
        check_eq("a_issued_gap",32'(issued),       0);
        step();
        check_eq("a_valid2",  32'(alu_valid), 1);
        check_eq("a_idx2",    32'(alu_idx),   2);
        check_eq("a_issued2", 32'(issued),    32'h04);
        step();
        check_eq("a_cnt2", 32'(inflight_cnt), 2);
        rs_ready     = 8'h00;
        alu_ack      = 1'b0;
        alu_done     = 1'b1;
        alu_done_idx = 3'd1;
        step();
        check_eq("a_clear1", 32'(rs_clear),     32'h02);
        check_eq("a_cnt_d1", 32'(inflight_cnt), 1);
        alu_done_idx = 3'd2;
        step();
        check_eq("a_clear2", 32'(rs_clear),     32'h04);
        check_eq("a_cnt_d2", 32'(inflight_cnt), 0);
        alu_done = 1'b0;
        step();
        check_eq("a_clear_off", 32'(rs_clear), 0);

        // In-flight limit, then a completion unblocks a third dispatch
        do_reset();
        rs_ready = 8'hFF;
        alu_ack  = 1'b1;
        repeat (6) step();
        check_eq("b_n_dispatch", 32'(n_hs),         2);
        check_eq("b_valid_hold", 32'(alu_valid),    0);
        check_eq("b_cnt_full",   32'(inflight_cnt), 2);
        check_eq("b_busy",       32'(busy),         1);
        alu_done     = 1'b1;
        alu_done_idx = 3'd0;
        step();
        check_eq("b_clear0", 32'(rs_clear),     32'h01);
        check_eq("b_cnt1",   32'(inflight_cnt), 1);
        alu_done = 1'b0;
        step();
        check_eq("b_valid3", 32'(alu_valid), 1);
        check_eq("b_idx3",   32'(alu_idx),   2);

        // Request held stable while the ALU stalls
        alu_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rs_ready = (i % 2 == 1) ? 8'hFF : 8'h00;
            step();
            check_eq("c_valid_held", 32'(alu_valid), 1);
            check_eq("c_idx_held",   32'(alu_idx),   2);
        end
        alu_ack = 1'b1;
        #1;
        check_eq("c_issued", 32'(issued), 32'h04);
        step();
        check_eq("c_cnt", 32'(inflight_cnt), 2);

        // Pointer at 7 selects 7 before wrapping to 0
        do_reset();
        rs_ready = 8'h40;
        alu_ack  = 1'b1;
        step();
        check_eq("d_idx6", 32'(alu_idx), 6);
        step();
        rs_ready = 8'b1000_0001;
        step();
        check_eq("d_valid7", 32'(alu_valid), 1);
        check_eq("d_idx7",   32'(alu_idx),   7);
        step();
        alu_done     = 1'b1;
        alu_done_idx = 3'd6;
        step();
        check_eq("d_clear6", 32'(rs_clear), 32'h40);
        alu_done = 1'b0;
        step();
        check_eq("d_valid0", 32'(alu_valid), 1);
        check_eq("d_idx0",   32'(alu_idx),   0);

        // Flush with two in flight drains silently; stray completion flags err
        do_reset();
        rs_ready = 8'h03;
        alu_ack  = 1'b1;
        repeat (4) step();
        check_eq("e_cnt2", 32'(inflight_cnt), 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("e_busy_drain",  32'(busy),         1);
        check_eq("e_valid_drain", 32'(alu_valid),    0);
        check_eq("e_cnt_drain",   32'(inflight_cnt), 2);
        alu_done     = 1'b1;
        alu_done_idx = 3'd0;
        step();
        check_eq("e_noclear0", 32'(rs_clear),     0);
        check_eq("e_cnt1",     32'(inflight_cnt), 1);
        alu_done_idx = 3'd1;
        step();
        check_eq("e_noclear1", 32'(rs_clear),     0);
        check_eq("e_cnt0",     32'(inflight_cnt), 0);
        check_eq("e_idle",     32'(busy),         0);
        check_eq("e_err_clean",32'(err),          0);
        rs_ready     = 8'h00;
        alu_done_idx = 3'd5;
        step();
        check_eq("e_err_set",  32'(err),          1);
        check_eq("e_cnt_keep", 32'(inflight_cnt), 0);
        check_eq("e_bad_clear",32'(rs_clear),     0);
        alu_done = 1'b0;
        step();
        check_eq("e_err_sticky", 32'(err), 1);

        // Flush during a request suppresses the handshake
        do_reset();
        rs_ready = 8'h01;
        step();
        check_eq("g_valid", 32'(alu_valid), 1);
        alu_ack = 1'b1;
        flush   = 1'b1;
        #1;
        check_eq("g_issued_supp", 32'(issued), 0);
        step();
        check_eq("g_valid_off", 32'(alu_valid),    0);
        check_eq("g_cnt",       32'(inflight_cnt), 0);
        check_eq("g_busy",      32'(busy),         0);
        flush    = 1'b0;
        alu_ack  = 1'b0;
        rs_ready = 8'h00;

        // Handshake coincident with completion, then async reset mid-request
        do_reset();
        rs_ready = 8'h03;
        alu_ack  = 1'b1;
        repeat (3) step();
        check_eq("f_valid1", 32'(alu_valid), 1);
        check_eq("f_idx1",   32'(alu_idx),   1);
        alu_done     = 1'b1;
        alu_done_idx = 3'd0;
        step();
        check_eq("f_cnt_same", 32'(inflight_cnt), 1);
        check_eq("f_clear0",   32'(rs_clear),     32'h01);
        alu_done = 1'b0;
        alu_ack  = 1'b0;
        rs_ready = 8'hFF;
        step();
        check_eq("f_valid2", 32'(alu_valid), 1);
        check_eq("f_idx2",   32'(alu_idx),   2);
        alu_ack = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_eq("f_rst_valid",  32'(alu_valid),    0);
        check_eq("f_rst_idx",    32'(alu_idx),      0);
        check_eq("f_rst_cnt",    32'(inflight_cnt), 0);
        check_eq("f_rst_busy",   32'(busy),         0);
        check_eq("f_rst_issued", 32'(issued),       0);
        check_eq("f_rst_clear",  32'(rs_clear),     0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("f_post_valid", 32'(alu_valid), 0);
        step();
        check_eq("f_first_valid", 32'(alu_valid), 1);
        check_eq("f_first_idx",   32'(alu_idx),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
